// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and the data memory port: issues one
// word-aligned access at a time, builds store lanes, returns raw load words.

module mem_access_unit_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_boff,
  input  logic [31:0] i_wdata,
  output logic        o_we,
  output logic [7:0]  o_byte
);
  localparam logic [1:0] L = 2'(LANE);

  // i_size is funct3[1:0]: 0 byte, 1 half, 2 word
  always_comb begin
    o_we   = 1'b0;
    o_byte = i_wdata[8*LANE +: 8];
    case (i_size)
      2'd0: begin
        o_we   = (i_boff == L);
        o_byte = i_wdata[7:0];
      end
      2'd1: begin
        o_we   = (i_boff[1] == L[1]);
        o_byte = i_wdata[8*(LANE%2) +: 8];
      end
      2'd2: begin
        o_we   = 1'b1;
        o_byte = i_wdata[8*LANE +: 8];
      end
      default: o_we = 1'b0;
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CW             = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DWIDTH-1:0]     req_inst,
  input  logic [DWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DWIDTH-1:0]     mem_addr,
  output logic [DWIDTH/8-1:0]   mem_we,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DWIDTH-1:0]     mem_resp_rdata,
  output logic                  ld_valid,
  output logic [DWIDTH-1:0]     ld_inst,
  output logic [DWIDTH-1:0]     ld_addr,
  output logic [DWIDTH-1:0]     ld_data,
  output logic                  st_done,
  output logic                  err_misaligned,
  output logic                  err_timeout
);
  localparam int NUM_LANES = DWIDTH / 8;
  localparam logic [6:0]    OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]    OPC_STORE = 7'b0100011;
  localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_is_load;
  logic [DWIDTH-1:0]   r_inst;
  logic [DWIDTH-1:0]   r_addr;

  logic [6:0]                    w_opc;
  logic [2:0]                    w_f3;
  logic                          w_is_load;
  logic                          w_is_store;
  logic                          w_misal;
  logic [CW-1:0]                 w_cnt_nxt;
  logic [NUM_LANES-1:0]          w_we;
  logic [NUM_LANES-1:0][7:0]     w_wdata;

  assign w_opc      = req_inst[6:0];
  assign w_f3       = req_inst[14:12];
  assign w_is_load  = (w_opc == OPC_LOAD);
  assign w_is_store = (w_opc == OPC_STORE);
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign req_ready  = (r_state == S_IDLE);

  // Unknown store widths are folded into the misaligned error class
  always_comb begin
    w_misal = 1'b0;
    if (w_is_load) begin
      case (w_f3)
        3'b001, 3'b101: w_misal = req_addr[0];
        3'b010:         w_misal = |req_addr[1:0];
        default:        w_misal = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (w_f3)
        3'b000:  w_misal = 1'b0;
        3'b001:  w_misal = req_addr[0];
        3'b010:  w_misal = |req_addr[1:0];
        default: w_misal = 1'b1;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_unit_lane #(.LANE(g)) u_lane (
      .i_size  (w_f3[1:0]),
      .i_boff  (req_addr[1:0]),
      .i_wdata (req_wdata),
      .o_we    (w_we[g]),
      .o_byte  (w_wdata[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_is_load      <= 1'b0;
      r_inst         <= '0;
      r_addr         <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_we         <= '0;
      mem_wdata      <= '0;
      ld_valid       <= 1'b0;
      ld_inst        <= '0;
      ld_addr        <= '0;
      ld_data        <= '0;
      st_done        <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      ld_valid       <= 1'b0;
      st_done        <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && (w_is_load || w_is_store)) begin
            if (w_misal) begin
              err_misaligned <= 1'b1;
            end else begin
              r_inst        <= req_inst;
              r_addr        <= req_addr;
              r_is_load     <= w_is_load;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[DWIDTH-1:2], 2'b00};
              mem_we        <= w_is_store ? w_we : '0;
              mem_wdata     <= w_is_store ? w_wdata : '0;
              r_state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (r_is_load) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              st_done <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          // A response on the final counted cycle still completes the load
          if (mem_resp_valid) begin
            ld_valid <= 1'b1;
            ld_data  <= mem_resp_rdata;
            ld_inst  <= r_inst;
            ld_addr  <= r_addr;
            r_state  <= S_IDLE;
          end else if (w_cnt_nxt == TO_LIM) begin
            err_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, stalls, timeout, reset.

module tb_mem_access_unit;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        ld_valid;
  logic [31:0] ld_inst;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        st_done;
  logic        err_misaligned;
  logic        err_timeout;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] pl;
  logic        bad;

  mem_access_unit #(.DWIDTH(32), .TIMEOUT_CYCLES(64), .CW(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_inst       (req_inst),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .ld_valid       (ld_valid),
    .ld_inst        (ld_inst),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .st_done        (st_done),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f3, input logic [6:0] opc,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_inst  = mk(f3, opc);
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_inst = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mvalid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_ldvalid", {31'd0, ld_valid}, 32'd0);
    chk("rst_errs", {29'd0, st_done, err_misaligned, err_timeout}, 32'd0);
    rst = 1'b0;
    step();

    // SB at 0x1001
    mem_req_ready = 1'b1;
    req(3'b000, OPC_STORE, 32'h1001, 32'h0000_00AB);
    step();
    req_valid = 1'b0;
    chk("sb_mvalid", {31'd0, mem_req_valid}, 32'd1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_we", {28'd0, mem_we}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_busy", {31'd0, req_ready}, 32'd0);
    step();
    chk("sb_done", {31'd0, st_done}, 32'd1);
    chk("sb_mdrop", {31'd0, mem_req_valid}, 32'd0);
    chk("sb_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("sb_done_pulse", {31'd0, st_done}, 32'd0);

    // LH at 0x2002, response one cycle after issue
    req(3'b001, OPC_LOAD, 32'h2002, 32'hFFFF_FFFF);
    step();
    req_valid = 1'b0;
    chk("lh_mvalid", {31'd0, mem_req_valid}, 32'd1);
    chk("lh_addr", mem_addr, 32'h2000);
    chk("lh_we", {28'd0, mem_we}, 32'h0);
    step();
    chk("lh_mdrop", {31'd0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h89AB_CDEF;
    step();
    mem_resp_valid = 1'b0;
    chk("lh_ldvalid", {31'd0, ld_valid}, 32'd1);
    chk("lh_data", ld_data, 32'h89AB_CDEF);
    chk("lh_ldaddr", ld_addr, 32'h2002);
    chk("lh_inst", ld_inst, 32'h0000_1003);
    pl = ld_addr[1] ? {{16{ld_data[31]}}, ld_data[31:16]} : {{16{ld_data[15]}}, ld_data[15:0]};
    chk("lh_partial", pl, 32'hFFFF_89AB);
    step();
    chk("lh_pulse", {31'd0, ld_valid}, 32'd0);
    chk("lh_hold", ld_data, 32'h89AB_CDEF);

    // SW misaligned, then bad store width, then non-memory opcode
    req(3'b010, OPC_STORE, 32'h3001, 32'h1234_5678);
    step();
    req_valid = 1'b0;
    chk("sw_mis_err", {31'd0, err_misaligned}, 32'd1);
    chk("sw_mis_noreq", {31'd0, mem_req_valid}, 32'd0);
    chk("sw_mis_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk("sw_mis_pulse", {31'd0, err_misaligned}, 32'd0);
    chk("sw_mis_noreq2", {31'd0, mem_req_valid}, 32'd0);
    req(3'b011, OPC_STORE, 32'h3000, 32'h0);
    step();
    req_valid = 1'b0;
    chk("badf3_err", {31'd0, err_misaligned}, 32'd1);
    chk("badf3_noreq", {31'd0, mem_req_valid}, 32'd0);
    req(3'b000, OPC_OP, 32'h3000, 32'h0);
    step();
    req_valid = 1'b0;
    chk("op_quiet", {29'd0, mem_req_valid, err_misaligned, st_done}, 32'd0);
    chk("op_ready", {31'd0, req_ready}, 32'd1);

    // LW with memory stalling 5 cycles
    mem_req_ready = 1'b0;
    req(3'b010, OPC_LOAD, 32'h4000, 32'h0);
    step();
    req_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!mem_req_valid || mem_addr !== 32'h4000 || mem_we !== 4'h0 || req_ready) bad = 1'b1;
      step();
    end
    chk("stall_stable", {31'd0, bad}, 32'd0);
    chk("stall_mvalid", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    step();
    chk("stall_mdrop", {31'd0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1122_3344;
    step();
    mem_resp_valid = 1'b0;
    chk("stall_ldvalid", {31'd0, ld_valid}, 32'd1);
    chk("stall_data", ld_data, 32'h1122_3344);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);

    // back-to-back SH accepted in the ld_valid cycle
    req(3'b001, OPC_STORE, 32'h5002, 32'h0000_BEEF);
    step();
    req_valid = 1'b0;
    chk("sh_mvalid", {31'd0, mem_req_valid}, 32'd1);
    chk("sh_addr", mem_addr, 32'h5000);
    chk("sh_we", {28'd0, mem_we}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    step();
    chk("sh_done", {31'd0, st_done}, 32'd1);

    // LW timeout: 64 WAIT_RESP cycles with no response
    req(3'b010, OPC_LOAD, 32'h6000, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    bad = 1'b0;
    for (int i = 1; i < 64; i++) begin
      step();
      if (err_timeout || ld_valid || req_ready) bad = 1'b1;
    end
    chk("to_quiet", {31'd0, bad}, 32'd0);
    step();
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_noload", {31'd0, ld_valid}, 32'd0);
    chk("to_ready", {31'd0, req_ready}, 32'd1);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_DEAD;
    step();
    mem_resp_valid = 1'b0;
    chk("to_pulse", {31'd0, err_timeout}, 32'd0);
    chk("late_resp_ignored", {31'd0, ld_valid}, 32'd0);

    // response on the last counted cycle beats the timeout
    req(3'b010, OPC_LOAD, 32'h8000, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    repeat (63) step();
    chk("race_pre", {31'd0, err_timeout}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    step();
    mem_resp_valid = 1'b0;
    chk("race_ldvalid", {31'd0, ld_valid}, 32'd1);
    chk("race_noerr", {31'd0, err_timeout}, 32'd0);
    chk("race_data", ld_data, 32'hCAFE_F00D);

    // reset while in WAIT_RESP, then a late response
    req(3'b010, OPC_LOAD, 32'h7000, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_ctrl", {27'd0, mem_req_valid, ld_valid, st_done, err_misaligned, err_timeout}, 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_lddata", ld_data, 32'h0);
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    chk("arst_noload", {31'd0, ld_valid}, 32'd0);
    step();
    chk("arst_noload2", {31'd0, ld_valid}, 32'd0);
    chk("arst_lddata2", ld_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
